// File: rtl/uart_pwm_pkg.sv
// Shared types and ASCII constants for the UART command parser.
package uart_pwm_pkg;
    localparam int DataWidthDef = 16;

    localparam logic [7:0] AsciiLf = 8'h0A;
    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiPu = 8'h50;
    localparam logic [7:0] AsciiDu = 8'h44;
    localparam logic [7:0] AsciiEu = 8'h45;
    localparam logic [7:0] AsciiPl = 8'h70;
    localparam logic [7:0] AsciiDl = 8'h64;
    localparam logic [7:0] AsciiEl = 8'h65;
    localparam logic [7:0] Ascii0  = 8'h30;
    localparam logic [7:0] Ascii1  = 8'h31;

    typedef enum logic [2:0] {
        IDLE, FETCH_OP, GET_ARG, FETCH_ARG,
        GET_EOS, FETCH_EOS, COMMIT, FLUSH
    } parser_state_t;

    typedef enum logic [1:0] {
        TGT_PERIOD, TGT_DUTY, TGT_EN
    } cmd_target_t;
endpackage

// File: rtl/uart_cmd_parser_if.sv
// RX FIFO read port: head byte, empty flag and pop strobe.
interface uart_cmd_parser_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_read;

    modport master (output fifo_data, output fifo_empty, input fifo_read);
    modport slave  (input fifo_data, input fifo_empty, output fifo_read);
endinterface

// File: rtl/uart_cmd_parser_hex.sv
// ASCII hex digit to nibble decoder (0-9, A-F, a-f).
module hex_nibble_decode (
    input  logic [7:0] data,
    output logic       valid,
    output logic [3:0] nibble
);
    always_comb begin
        valid  = 1'b1;
        nibble = 4'd0;
        unique case (1'b1)
            (data >= 8'h30 && data <= 8'h39): nibble = data[3:0];
            (data >= 8'h41 && data <= 8'h46): nibble = data[3:0] + 4'd9;
            (data >= 8'h61 && data <= 8'h66): nibble = data[3:0] + 4'd9;
            default:                          valid  = 1'b0;
        endcase
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser driving the PWM configuration registers.
// Define CMD_TIMEOUT_EN to abandon partial commands after TimeoutCycles idle cycles.
module uart_cmd_parser
    import uart_pwm_pkg::*;
#(
    parameter int                   DataWidth     = DataWidthDef,
    parameter logic [DataWidth-1:0] ResetPeriod   = 16'd1000,
    parameter logic [DataWidth-1:0] ResetDuty     = 16'd500,
    parameter int                   TimeoutCycles = 5_000_000
) (
    input  logic                  clk_50mhz,
    input  logic                  rst,
    uart_cmd_parser_if.slave      fifo,
    output logic [DataWidth-1:0]  period,
    output logic [DataWidth-1:0]  duty,
    output logic                  pwm_en,
    output logic                  cfg_update,
    output logic                  cmd_error
);
    localparam int Digits = DataWidth / 4;
    localparam int CntW   = $clog2(Digits + 1);

    parser_state_t        state_q, state_d;
    cmd_target_t          tgt_q, tgt_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 rd, tmo_hit, hex_valid, arg_ok;
    logic                 is_lf, is_cr;
    logic [3:0]           hex_nib;
    logic [7:0]           rx;

    assign rx    = fifo.fifo_data;
    assign is_lf = (rx == AsciiLf);
    assign is_cr = (rx == AsciiCr);
    assign fifo.fifo_read = rd;

    hex_nibble_decode u_hex (
        .data   (rx),
        .valid  (hex_valid),
        .nibble (hex_nib)
    );

    assign arg_ok = (tgt_q == TGT_EN) ? (rx == Ascii0 || rx == Ascii1)
                                      : hex_valid;

`ifdef CMD_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles);
    logic [TmoW-1:0] tmo_q;
    logic            sample;

    assign sample = (state_q inside {FETCH_OP, FETCH_ARG, FETCH_EOS})
                 || (state_q == FLUSH && pend_q);

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst)                          tmo_q <= '0;
        else if (state_q == IDLE || sample) tmo_q <= '0;
        else                              tmo_q <= tmo_q + TmoW'(1);
    end

    assign tmo_hit = (tmo_q == TmoW'(TimeoutCycles - 1)) && !sample
                  && state_q != IDLE && state_q != COMMIT;
`else
    assign tmo_hit = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        rd         = 1'b0;
        cfg_update = 1'b0;
        cmd_error  = 1'b0;
        unique case (state_q)
            IDLE, GET_ARG, GET_EOS: begin
                if (!fifo.fifo_empty) begin
                    rd = 1'b1;
                    state_d = (state_q == IDLE)    ? FETCH_OP :
                              (state_q == GET_ARG) ? FETCH_ARG : FETCH_EOS;
                end
            end
            FETCH_OP: begin
                acc_d = '0;
                cnt_d = CntW'(Digits);
                if (is_cr || is_lf) begin
                    state_d = IDLE;
                end else if (rx == AsciiPu || rx == AsciiPl) begin
                    tgt_d   = TGT_PERIOD;
                    state_d = GET_ARG;
                end else if (rx == AsciiDu || rx == AsciiDl) begin
                    tgt_d   = TGT_DUTY;
                    state_d = GET_ARG;
                end else if (rx == AsciiEu || rx == AsciiEl) begin
                    tgt_d   = TGT_EN;
                    cnt_d   = CntW'(1);
                    state_d = GET_ARG;
                end else begin
                    cmd_error = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = FLUSH;
                end
            end
            FETCH_ARG: begin
                if (is_cr) begin
                    state_d = GET_ARG;
                end else if (is_lf) begin
                    cmd_error = 1'b1;
                    state_d   = IDLE;
                end else if (arg_ok) begin
                    acc_d   = {acc_q[DataWidth-5:0], hex_nib};
                    cnt_d   = cnt_q - CntW'(1);
                    state_d = (cnt_q == CntW'(1)) ? GET_EOS : GET_ARG;
                end else begin
                    cmd_error = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = FLUSH;
                end
            end
            FETCH_EOS: begin
                if (is_cr) begin
                    state_d = GET_EOS;
                end else if (is_lf) begin
                    state_d = COMMIT;
                end else begin
                    cmd_error = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = FLUSH;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // Duty may never exceed the period it modulates.
                if (tgt_q == TGT_DUTY && acc_q > period) cmd_error  = 1'b1;
                else                                     cfg_update = 1'b1;
            end
            FLUSH: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (is_lf) state_d = IDLE;
                end else if (!fifo.fifo_empty) begin
                    rd     = 1'b1;
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_hit) begin
            state_d    = IDLE;
            pend_d     = 1'b0;
            rd         = 1'b0;
            cfg_update = 1'b0;
            cmd_error  = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= TGT_PERIOD;
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            period <= ResetPeriod;
            duty   <= ResetDuty;
            pwm_en <= 1'b0;
        end else if (cfg_update) begin
            case (tgt_q)
                TGT_PERIOD: begin
                    period <= acc_q;
                    if (acc_q < duty) duty <= acc_q;
                end
                TGT_DUTY: duty   <= acc_q;
                TGT_EN:   pwm_en <= acc_q[0];
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench: random command lines vs a line-level reference model.
module tb_uart_cmd_parser;
`ifdef CMD_TIMEOUT_EN
    localparam int Tmo = 100;
`else
    localparam int Tmo = 5_000_000;
`endif

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic [15:0] period, duty;
    logic        pwm_en, cfg_update, cmd_error;

    uart_cmd_parser_if fifo_if ();

    uart_cmd_parser #(
        .DataWidth     (16),
        .ResetPeriod   (16'd1000),
        .ResetDuty     (16'd500),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .fifo       (fifo_if),
        .period     (period),
        .duty       (duty),
        .pwm_en     (pwm_en),
        .cfg_update (cfg_update),
        .cmd_error  (cmd_error)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct packed {
        bit          err;
        logic [15:0] p;
        logic [15:0] d;
        bit          en;
    } exp_t;

    logic [7:0] fq[$];
    exp_t       sbq[$];
    exp_t       cur;
    int         n_pass = 0;
    int         n_checks = 0;
    logic [15:0] m_period = 16'd1000;
    logic [15:0] m_duty = 16'd500;
    bit          m_en = 1'b0;
    string       m_line = "";
    bit          chk_pend = 1'b0;
    bit          prev_rd = 1'b0;

    // FIFO model: byte appears on fifo_data the cycle after the pop.
    always @(posedge clk_50mhz) begin
        if (fifo_if.fifo_read && fq.size() > 0)
            fifo_if.fifo_data <= fq.pop_front();
        fifo_if.fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    task automatic expect_evt(input bit err);
        exp_t e;
        e.err = err;
        e.p   = m_period;
        e.d   = m_duty;
        e.en  = m_en;
        sbq.push_back(e);
    endtask

    // One complete line (CRs stripped) yields at most one event.
    task automatic eval_line(input string l);
        logic [7:0] op;
        int n, v, h;
        bit ok;
        if (l.len() == 0) return;
        op = l[0];
        if (op >= "a" && op <= "z") op = op - 8'h20;
        n  = (op == "P" || op == "D") ? 4 : (op == "E") ? 1 : 0;
        ok = (n > 0) && (l.len() == n + 1);
        v  = 0;
        for (int i = 1; i < l.len() && ok; i++) begin
            h = hexval(l[i]);
            if (h < 0) ok = 0;
            if (op == "E" && !(l[i] == "0" || l[i] == "1")) ok = 0;
            v = v * 16 + h;
        end
        if (!ok || (op == "D" && v > int'(m_period))) begin
            expect_evt(1'b1);
        end else begin
            if (op == "P") begin
                m_period = 16'(v);
                if (16'(v) < m_duty) m_duty = 16'(v);
            end else if (op == "D") begin
                m_duty = 16'(v);
            end else begin
                m_en = (v != 0);
            end
            expect_evt(1'b0);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            fq.push_back(s[i]);
            if (s[i] == 8'h0A) begin
                eval_line(m_line);
                m_line = "";
            end else if (s[i] != 8'h0D) begin
                m_line = $sformatf("%s%c", m_line, s[i]);
            end
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((fq.size() != 0 || sbq.size() != 0) && k < 3000) begin
            @(negedge clk_50mhz);
            k++;
        end
        repeat (4) @(negedge clk_50mhz);
        chk(fq.size() == 0 && sbq.size() == 0,
            $sformatf("drain_%s fifo=%0d pending=%0d required 0/0",
                      name, fq.size(), sbq.size()));
    endtask

    task automatic model_reset();
        m_period = 16'd1000;
        m_duty   = 16'd500;
        m_en     = 1'b0;
        m_line   = "";
    endtask

    task automatic check_reset_vals(input string name);
        chk(period == 16'd1000 && duty == 16'd500,
            $sformatf("%s_regs period=%0d duty=%0d required 1000/500",
                      name, period, duty));
        chk({pwm_en, fifo_if.fifo_read, cfg_update, cmd_error} == 4'b0,
            $sformatf("%s_bits en/rd/upd/err=%b required 0000", name,
                      {pwm_en, fifo_if.fifo_read, cfg_update, cmd_error}));
    endtask

    function automatic string rand_line();
        string s, args;
        string ops = "PDE";
        string junk = "XZ!q9 #";
        logic [7:0] op;
        logic [15:0] v;
        int k;
        k  = $urandom_range(0, 9);
        op = ops[$urandom_range(0, 2)];
        if ($urandom_range(0, 1) == 1) op = op + 8'h20;
        v  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 16'hFFFF))
                                          : 16'($urandom_range(0, 16'h0400));
        args = ($urandom_range(0, 1) == 1) ? $sformatf("%04x", v)
                                           : $sformatf("%04X", v);
        case (k)
            0, 1, 2, 3, 4: begin
                if (op == "E" || op == "e")
                    s = $sformatf("%c%0d", op, $urandom_range(0, 1));
                else
                    s = $sformatf("%c%s", op, args);
            end
            5: s = $sformatf("%c%s", op, args.substr(0, $urandom_range(0, 2)));
            6: s = $sformatf("%c%sG%s", op, args.substr(0, 0), args.substr(1, 2));
            7: s = $sformatf("%c%s", junk[$urandom_range(0, 6)], args);
            8: s = "";
            default: s = $sformatf("%c%s5", op, args);
        endcase
        if ($urandom_range(0, 3) == 0) s = {"\r", s};
        if ($urandom_range(0, 3) == 0) s = {s, "\r"};
        return {s, "\n"};
    endfunction

    always @(negedge clk_50mhz) begin
        if (rst) begin
            prev_rd  = 1'b0;
            chk_pend = 1'b0;
        end else begin
            if (chk_pend) begin
                chk_pend = 1'b0;
                chk({period, duty, pwm_en} == {cur.p, cur.d, cur.en},
                    $sformatf("regs_after_event period=%h duty=%h en=%0b required %h %h %0b",
                              period, duty, pwm_en, cur.p, cur.d, cur.en));
            end
            if (fifo_if.fifo_read)
                chk(!fifo_if.fifo_empty && !prev_rd,
                    $sformatf("read_strobe empty=%0b prev_read=%0b required 0/0",
                              fifo_if.fifo_empty, prev_rd));
            prev_rd = fifo_if.fifo_read;
            if (cfg_update || cmd_error) begin
                chk(!(cfg_update && cmd_error),
                    $sformatf("pulse_exclusive upd=%0b err=%0b required not both",
                              cfg_update, cmd_error));
                chk(sbq.size() != 0,
                    $sformatf("unexpected_event upd=%0b err=%0b required none",
                              cfg_update, cmd_error));
                if (sbq.size() != 0) begin
                    cur = sbq.pop_front();
                    chk(cmd_error == cur.err,
                        $sformatf("event_kind err=%0b upd=%0b required err=%0b",
                                  cmd_error, cfg_update, cur.err));
                    chk_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk_50mhz);

        send("P07D0\n");
        drain("p07d0");
        chk(period == 16'h07D0, $sformatf("period_set period=%h required 07d0", period));

        send("d03e8\r\n");
        drain("d03e8");
        chk(duty == 16'h03E8, $sformatf("duty_set duty=%h required 03e8", duty));

        send("D0800\n");
        drain("d_over");
        chk(duty == 16'h03E8, $sformatf("duty_reject duty=%h required 03e8", duty));

        send("P0100\n");
        drain("p_clamp");
        chk(period == 16'h0100 && duty == 16'h0100,
            $sformatf("period_clamp period=%h duty=%h required 0100/0100", period, duty));

        send("X12\nE1\n");
        drain("flush_e1");
        chk(pwm_en == 1'b1, $sformatf("enable_set en=%0b required 1", pwm_en));

        send("P0G00\n");
        drain("bad_hex");
        chk(period == 16'h0100, $sformatf("bad_hex_period period=%h required 0100", period));

        send("P12");
        k = 0;
        while (fq.size() != 0 && k < 200) begin
            @(negedge clk_50mhz);
            k++;
        end
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_vals("midcmd_reset");
        @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        send("E1\n");
        drain("after_reset");
        chk(pwm_en == 1'b1, $sformatf("after_reset_en en=%0b required 1", pwm_en));

`ifdef CMD_TIMEOUT_EN
        send("P1");
        k = 0;
        while (fq.size() != 0 && k < 200) begin
            @(negedge clk_50mhz);
            k++;
        end
        repeat (3) @(negedge clk_50mhz);
        m_line = "";
        expect_evt(1'b1);
        repeat (Tmo + 20) @(negedge clk_50mhz);
        chk(sbq.size() == 0, $sformatf("timeout_error pending=%0d required 0", sbq.size()));
        send("P0010\n");
        drain("after_timeout");
        chk(period == 16'h0010, $sformatf("timeout_period period=%h required 0010", period));
`endif

        repeat (40) begin
            repeat (4) send(rand_line());
            drain("random");
        end

        chk({period, duty, pwm_en} == {m_period, m_duty, m_en},
            $sformatf("final_regs period=%h duty=%h en=%0b required %h %h %0b",
                      period, duty, pwm_en, m_period, m_duty, m_en));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
